// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : State encodings and default width shared by the timer blocks.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } timer_state_t;

endpackage
`default_nettype wire

// File: rtl/capture_if.sv
`default_nettype none
// ============================================================================
// Module   : capture_if
// Brief    : Event input, control and result handshake of the capture timer.
// Revision : 1.0 - initial release
// ============================================================================
interface capture_if
    import timer_pkg::*;
#(
    parameter int W = TIMER_W
) ();

    logic         enable;
    logic         sense;
    logic         get;
    logic [W-1:0] value;
    logic         full;
    logic         over;
    logic         lost;

    modport master (
        output enable, sense, get,
        input  value, full, over, lost
    );

    modport slave (
        input  enable, sense, get,
        output value, full, over, lost
    );

endinterface
`default_nettype wire

// File: rtl/edge_sense.sv
`default_nettype none
// ============================================================================
// Module   : edge_sense
// Brief    : Rising-edge detector; CAPTURE_SYNC_EN adds a 2-flop synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
module edge_sense (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic in,
    output logic      rise
);

    logic w_in;
    logic r_q;

`ifdef CAPTURE_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], in};
        end
    end

    assign w_in = r_sync[1];
`else
    assign w_in = in;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_in;
        end
    end

    assign rise = w_in & ~r_q;

endmodule
`default_nettype wire

// File: rtl/capture.sv
`default_nettype none
// ============================================================================
// Module   : capture
// Brief    : Input-capture timer measuring clock cycles between rising edges
//            of sense; optional CAPTURE_SYNC_EN synchronizes sense.
// Revision : 1.0 - initial release
// ============================================================================
module capture
    import timer_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  wire logic  clock,
    input  wire logic  reset,
    capture_if.slave   bus
);

    localparam logic [W-1:0] c_count_max = '1;
    localparam logic [W-1:0] c_count_one = {{(W-1){1'b0}}, 1'b1};

    timer_state_t r_state;
    timer_state_t w_state_nxt;
    logic [W-1:0] r_count;
    logic [W-1:0] w_count_nxt;
    logic         w_capture;
    logic         w_rise;

    logic [W-1:0] r_value;
    logic         r_full;
    logic         r_over;
    logic         r_lost;

    edge_sense u_edge_sense (
        .clock (clock),
        .reset (reset),
        .in    (bus.sense),
        .rise  (w_rise)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Disable overrides everything, including an edge on the same clock.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_capture   = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ARMED;
                    w_count_nxt = '0;
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        w_state_nxt = ST_RUN;
                        w_count_nxt = c_count_one;
                    end
                end
                ST_RUN: begin
                    if (w_rise) begin
                        w_capture   = 1'b1;
                        w_count_nxt = c_count_one;
                    end else if (r_count != c_count_max) begin
                        w_count_nxt = r_count + c_count_one;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    // A capture takes priority over get; an unacknowledged overwrite is sticky.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_value <= '0;
            r_full  <= 1'b0;
            r_over  <= 1'b0;
            r_lost  <= 1'b0;
        end else if (w_capture) begin
            r_value <= r_count;
            r_over  <= (r_count == c_count_max);
            r_full  <= 1'b1;
            if (r_full && !bus.get) begin
                r_lost <= 1'b1;
            end
        end else if (bus.get && r_full) begin
            r_full <= 1'b0;
        end
    end

    assign bus.value = r_value;
    assign bus.full  = r_full;
    assign bus.over  = r_over;
    assign bus.lost  = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture
// Brief    : Scoreboard bench for capture; latency follows CAPTURE_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture;

    localparam int W = 8;
`ifdef CAPTURE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int         due;
        logic [7:0] val;
        logic       ovr;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    capture_if #(.W(W)) bus ();

    capture #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    logic get_s    = 1'b0;
    logic reset_s  = 1'b1;

    exp_t sb[$];
    exp_t e;
    bit   armed = 1'b0;
    int   last  = 0;

    logic [7:0] m_value = 8'h00;
    logic       m_full  = 1'b0;
    logic       m_over  = 1'b0;
    logic       m_lost  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        get_s   <= bus.get;
        reset_s <= reset;
    end

    // Consumer-side view of the result registers, advanced by scoreboard pops.
    always @(negedge clock) begin
        if (reset_s) begin
            m_value = 8'h00;
            m_full  = 1'b0;
            m_over  = 1'b0;
            m_lost  = 1'b0;
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("sb_value", {24'd0, bus.value}, {24'd0, e.val});
            check("sb_over", {31'd0, bus.over}, {31'd0, e.ovr});
            if (m_full && !get_s) m_lost = 1'b1;
            m_full  = 1'b1;
            m_value = e.val;
            m_over  = e.ovr;
        end else if (get_s && m_full) begin
            m_full = 1'b0;
        end
        check("outputs", {21'd0, bus.value, bus.over, bus.full, bus.lost},
              {21'd0, m_value, m_over, m_full, m_lost});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_reset();
        sb.delete();
        armed = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_state", {21'd0, bus.value, bus.over, bus.full, bus.lost}, 32'd0);
        reset = 1'b0;
        idle(2);
    endtask

    task automatic pulse(input bit with_get);
        int         c;
        int         n;
        logic [7:0] v;
        c = cyc;
        if (armed) begin
            n = c - last;
            v = (n >= 255) ? 8'hFF : n[7:0];
            sb.push_back('{c + LAT, v, (n >= 255)});
        end
        armed = 1'b1;
        last  = c;
        bus.sense = 1'b1;
        if (with_get && LAT == 1) bus.get = 1'b1;
        tick();
        bus.sense = 1'b0;
        bus.get   = 1'b0;
        if (with_get && LAT > 1) begin
            wait_until(c + LAT - 1);
            bus.get = 1'b1;
            tick();
            bus.get = 1'b0;
        end
    endtask

    task automatic pulse_after(input int p, input bit with_get);
        wait_until(last + p);
        pulse(with_get);
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.sense  = 1'b0;
        bus.get    = 1'b0;
        idle(2);
        bus.enable = 1'b1;
        do_reset();

        // 1: period 17, three edges, never acknowledged
        pulse(0);
        pulse_after(17, 0);
        pulse_after(17, 0);
        idle(LAT + 1);
        check("t1_value", {24'd0, bus.value}, 32'h11);
        check("t1_full", {31'd0, bus.full}, 32'd1);

        // 2: period 7, get after each result
        do_reset();
        pulse(0);
        repeat (3) begin
            pulse_after(7, 0);
            idle(LAT);
            check("t2_full_set", {31'd0, bus.full}, 32'd1);
            check("t2_value", {24'd0, bus.value}, 32'h07);
            bus.get = 1'b1;
            tick();
            bus.get = 1'b0;
            check("t2_full_clr", {31'd0, bus.full}, 32'd0);
        end
        check("t2_lost", {31'd0, bus.lost}, 32'd0);

        // 3: period 7, never acknowledged
        do_reset();
        pulse(0);
        pulse_after(7, 0);
        pulse_after(7, 0);
        idle(LAT + 1);
        check("t3_value", {24'd0, bus.value}, 32'h07);
        check("t3_lost", {31'd0, bus.lost}, 32'd1);
        idle(10);
        check("t3_lost_sticky", {31'd0, bus.lost}, 32'd1);

        // 4: saturation, then a short interval
        do_reset();
        pulse(0);
        pulse_after(300, 0);
        idle(LAT + 1);
        check("t4_sat_value", {24'd0, bus.value}, 32'hFF);
        check("t4_sat_over", {31'd0, bus.over}, 32'd1);
        pulse_after(5, 0);
        idle(LAT + 1);
        check("t4_value", {24'd0, bus.value}, 32'h05);
        check("t4_over", {31'd0, bus.over}, 32'd0);

        // 5: reset mid-interval after a 9-cycle capture
        do_reset();
        pulse(0);
        pulse_after(9, 0);
        idle(LAT + 1);
        check("t5_value", {24'd0, bus.value}, 32'h09);
        idle(3);
        do_reset();
        pulse(0);
        idle(LAT + 2);
        check("t5_rearm", {31'd0, bus.full}, 32'd0);
        pulse_after(6, 0);
        idle(LAT + 1);
        check("t5_true_value", {24'd0, bus.value}, 32'h06);

        // 6: enable gap, then get and capture on the same clock
        do_reset();
        pulse(0);
        pulse_after(8, 0);
        idle(LAT + 2);
        bus.enable = 1'b0;
        armed = 1'b0;
        idle(4);
        bus.enable = 1'b1;
        idle(3);
        pulse(0);
        idle(LAT + 1);
        check("t6_gap_hold", {24'd0, bus.value}, 32'h08);
        pulse_after(10, 1);
        idle(LAT + 1);
        check("t6_same_value", {24'd0, bus.value}, 32'h0A);
        check("t6_same_full", {31'd0, bus.full}, 32'd1);
        check("t6_same_lost", {31'd0, bus.lost}, 32'd0);
        idle(3);
        bus.enable = 1'b0;
        armed = 1'b0;
        pulse(0);
        armed = 1'b0;
        idle(4);
        bus.enable = 1'b1;
        idle(3);
        check("t6_en_edge", {24'd0, bus.value}, 32'h0A);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
